// File: rtl/mem_stage_if.sv
// ============================================================================
// Module      : mem_stage_if
// Description : Data-memory request/response bus between mem_stage and dmem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : rv32i MEM stage; issues data-memory transactions and stalls
//               the pipeline until each one completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        valid_in,
  input  wire logic        mem_read,
  input  wire logic        mem_write,
  input  wire logic [2:0]  funct3,
  input  wire logic [31:0] alu_res,
  input  wire logic [31:0] rs2_data,
  input  wire logic        hold_in,
  mem_stage_if.master      dmem,
  output logic [31:0]      mem_rdata,
  output logic [1:0]       bit_shift,
  output logic             misalign,
  output logic             stall_out,
  output logic             timeout_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        mem_op;
  logic        is_store;
  logic        op;
  logic [3:0]  base_mask;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] cnt_inc;

  assign mem_op    = valid_in & (mem_read | mem_write);
  assign is_store  = mem_write;
  assign bit_shift = alu_res[1:0];

  // Illegal encodings are folded into misalign so they never start a transaction.
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      if (is_store && (funct3 > 3'b010)) begin
        misalign = 1'b1;
      end
      if (!is_store && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))) begin
        misalign = 1'b1;
      end
      if ((funct3[1:0] == 2'b01) && alu_res[0]) begin
        misalign = 1'b1;
      end
      if ((funct3[1:0] == 2'b10) && (alu_res[1:0] != 2'b00)) begin
        misalign = 1'b1;
      end
    end
  end

  assign op = mem_op & ~misalign;

  always_comb begin
    case (funct3[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  assign lane_mask = base_mask << alu_res[1:0];
  assign lane_data = rs2_data << {alu_res[1:0], 3'b000};
  assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (op) state_d = S_ACCESS;
      S_ACCESS: if (dmem.dmem_resp) state_d = S_DONE;
      S_DONE:   if (!hold_in) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_out = 1'b0;
    case (state_q)
      S_IDLE:   stall_out = op;
      S_ACCESS: stall_out = 1'b1;
      default:  stall_out = 1'b0;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    read_d  = read_q;
    write_d = write_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if ((state_q == S_IDLE) && op) begin
      addr_d  = {alu_res[31:2], 2'b00};
      read_d  = ~is_store;
      write_d = is_store;
      wmask_d = is_store ? lane_mask : 4'b0000;
      wdata_d = is_store ? lane_data : 32'd0;
    end
    if (state_q == S_ACCESS) begin
      cnt_d = cnt_inc;
      if ((TIMEOUT_CYCLES != 0) && (cnt_inc >= TIMEOUT_CYCLES)) begin
        err_d = 1'b1;
      end
      if (dmem.dmem_resp) begin
        if (read_q) rdata_d = dmem.dmem_rdata;
        read_d  = 1'b0;
        write_d = 1'b0;
        cnt_d   = 32'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= 32'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wmask_q <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign dmem.dmem_address = addr_q;
  assign dmem.dmem_read    = read_q;
  assign dmem.dmem_write   = write_q;
  assign dmem.dmem_wmask   = wmask_q;
  assign dmem.dmem_wdata   = wdata_q;
  assign mem_rdata         = rdata_q;
  assign timeout_err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read, mem_write, hold_in;
  logic [2:0]  funct3;
  logic [31:0] alu_res, rs2_data;
  logic [31:0] mem_rdata;
  logic [1:0]  bit_shift;
  logic        misalign, stall_out, timeout_err;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .alu_res     (alu_res),
    .rs2_data    (rs2_data),
    .hold_in     (hold_in),
    .dmem        (bus.master),
    .mem_rdata   (mem_rdata),
    .bit_shift   (bit_shift),
    .misalign    (misalign),
    .stall_out   (stall_out),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules: size in bytes from funct3, legality by direction, alignment by modulo.
  function automatic bit ref_misalign(input bit v, input bit rd, input bit wr,
                                      input logic [2:0] f3, input logic [31:0] a);
    int  nbytes;
    bit  legal;
    if (!(v && (rd || wr))) return 1'b0;
    if (wr) legal = (f3 <= 3'd2);
    else    legal = !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
    nbytes = 1 << f3[1:0];
    return !legal || ((a % 32'(nbytes)) != 0);
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge on which the pipeline advances.
  task automatic run_instr(input string tag, input bit v, input bit rd, input bit wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input int delay, input int hold_n, input logic [31:0] rdata);
    bit          exp_mis, exp_op, is_load, advanced;
    int          nbytes, off, stall_n, req_n, held;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata, exp_addr;
    valid_in  = v;   mem_read = rd;  mem_write = wr;
    funct3    = f3;  alu_res  = a;   rs2_data  = d;
    hold_in   = (hold_n > 0);
    exp_mis   = ref_misalign(v, rd, wr, f3, a);
    exp_op    = v && (rd || wr) && !exp_mis;
    is_load   = !wr;
    nbytes    = 1 << f3[1:0];
    off       = int'(a % 32'd4);
    exp_mask  = wr ? 4'(((1 << nbytes) - 1) << off) : 4'd0;
    exp_wdata = wr ? (d << (8 * off)) : 32'd0;
    exp_addr  = a - (a % 32'd4);
    stall_n = 0; req_n = 0; held = 0; advanced = 0;
    for (int cyc = 0; cyc < 100 && !advanced; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check({tag, "_misalign"}, 32'(misalign), 32'(exp_mis));
        check({tag, "_bit_shift"}, 32'(bit_shift), 32'(off));
      end
      if (stall_out) stall_n++;
      if (bus.dmem_read || bus.dmem_write) begin
        req_n++;
        if (req_n == 1) begin
          check({tag, "_addr"}, bus.dmem_address, exp_addr);
          check({tag, "_rd"}, 32'(bus.dmem_read), 32'(is_load));
          check({tag, "_wr"}, 32'(bus.dmem_write), 32'(wr));
          check({tag, "_wmask"}, 32'(bus.dmem_wmask), 32'(exp_mask));
          check({tag, "_wdata"}, bus.dmem_wdata, exp_wdata);
        end
        if (req_n == delay + 1) begin
          bus.dmem_resp  = 1'b1;
          bus.dmem_rdata = rdata;
          if (is_load) model_rdata = rdata;
        end
      end
      if (!stall_out) begin
        check({tag, "_rdata"}, mem_rdata, model_rdata);
        if (held < hold_n) held++;
        else begin
          hold_in  = 1'b0;
          advanced = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      bus.dmem_resp = 1'b0;
    end
    if (!advanced) check({tag, "_advance_bound"}, 32'd0, 32'd1);
    check({tag, "_stall_cycles"}, 32'(stall_n), exp_op ? 32'(delay + 2) : 32'd0);
    check({tag, "_req_cycles"}, 32'(req_n), exp_op ? 32'(delay + 1) : 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int          kind;
    rst = 1'b0; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hold_in = 1'b0;
    funct3 = 3'd0; alu_res = 32'd0; rs2_data = 32'd0;
    bus.dmem_resp = 1'b0; bus.dmem_rdata = 32'd0;
    model_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read",  32'(bus.dmem_read), 32'd0);
    check("rst_write", 32'(bus.dmem_write), 32'd0);
    check("rst_addr",  bus.dmem_address, 32'd0);
    check("rst_wmask", 32'(bus.dmem_wmask), 32'd0);
    check("rst_wdata", bus.dmem_wdata, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_err",   32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_instr("lw_basic", 1, 1, 0, 3'b010, 32'h100, 32'd0, 1, 0, 32'hDEADBEEF);
    run_instr("sb_lane3", 1, 0, 1, 3'b000, 32'h203, 32'h000000AB, 0, 0, 32'd0);
    run_instr("sh_misal", 1, 0, 1, 3'b001, 32'h101, 32'h1234, 0, 0, 32'd0);
    run_instr("lw_hold",  1, 1, 0, 3'b010, 32'h104, 32'd0, 0, 4, 32'hCAFEF00D);
    run_instr("nop",      1, 0, 0, 3'b000, 32'h0, 32'd0, 0, 0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(1, 3);
      if ($urandom_range(0, 4) == 0) kind = 0;
      ra = $urandom();
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      run_instr("rand", $urandom_range(0, 7) != 0, kind[0], kind[1],
                3'($urandom_range(0, 7)), ra, $urandom(),
                $urandom_range(0, 5), $urandom_range(0, 2), $urandom());
    end
    check("rand_no_timeout", 32'(timeout_err), 32'd0);

    // Response withheld: error flag rises after the eighth ACCESS cycle, access still completes.
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_res = 32'h40; hold_in = 1'b0;
    @(negedge clk);
    check("to_idle_stall", 32'(stall_out), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("to_read_held", 32'(bus.dmem_read), 32'd1);
      if (k == 8) check("to_err_pre", 32'(timeout_err), 32'd0);
    end
    @(negedge clk);
    check("to_err_set", 32'(timeout_err), 32'd1);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h12345678;
    model_rdata = 32'h12345678;
    @(posedge clk);
    #1;
    bus.dmem_resp = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    check("to_done_stall", 32'(stall_out), 32'd0);
    check("to_rdata", mem_rdata, model_rdata);
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    check("to_read_clr", 32'(bus.dmem_read), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of an access.
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_res = 32'h80;
    repeat (3) @(negedge clk);
    check("mr_read_before", 32'(bus.dmem_read), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    model_rdata = 32'd0;
    check("mr_read_drop", 32'(bus.dmem_read), 32'd0);
    check("mr_addr_clr", bus.dmem_address, 32'd0);
    check("mr_err_clr", 32'(timeout_err), 32'd0);
    check("mr_rdata_clr", mem_rdata, 32'd0);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hFFFF0000;
    @(posedge clk);
    #1;
    bus.dmem_resp = 1'b0;
    @(negedge clk);
    check("mr_late_resp_stall", 32'(stall_out), 32'd0);
    check("mr_late_resp_rdata", mem_rdata, 32'd0);
    check("mr_late_resp_read", 32'(bus.dmem_read), 32'd0);
    @(posedge clk);
    #1;
    run_instr("lw_after_rst", 1, 1, 0, 3'b100, 32'h301, 32'd0, 2, 1, 32'h0BADCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
